apb_master_bridge: RTL

- Initiator end of the peripheral APB bus.
- Converts a single-outstanding req/gnt/rvalid core-side request port into APB3 SETUP/ACCESS transfers.
- Sits between the core data path and the APB peripheral fabric, in the UART..DEBUG window 0x1A10_0000-0x1A11_7FFF.
- Adds two protections: a window check, which answers out-of-range accesses locally with an error, and a PREADY timeout, which prevents a hung slave from stalling the core.

---
 rtl/apb_master_bridge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// Core-side req/gnt/rvalid to APB3 initiator bridge.
// Forwards only the configured address window and bounds PREADY wait states with a timeout.
module apb_master_bridge #(
   parameter int unsigned                APB_ADDR_WIDTH = 32,
   parameter int unsigned                APB_DATA_WIDTH = 32,
   parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A10_0000,
   parameter logic [APB_ADDR_WIDTH-1:0] END_ADDR       = 32'h1A11_7FFF,
   parameter int unsigned                TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      req_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic                      req_we_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      gnt_o,
   output logic                      rvalid_o,
   output logic [APB_DATA_WIDTH-1:0] rdata_o,
   output logic                      err_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr,
   output logic [APB_DATA_WIDTH-1:0] pwdata,
   output logic                      pwrite,
   output logic                      psel,
   output logic                      penable,
   input  logic [APB_DATA_WIDTH-1:0] prdata,
   input  logic                      pready,
   input  logic                      pslverr
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                    state_q, state_d;
   logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      we_q, we_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      in_range;

   assign in_range = (req_addr_i >= BASE_ADDR) && (req_addr_i <= END_ADDR);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               addr_d  = req_addr_i;
               we_d    = req_we_i;
               wdata_d = req_wdata_i;
               if (in_range) begin
                  state_d = StSetup;
               end else begin
                  // Out-of-window access is answered locally, no APB cycle
                  state_d = StResp;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end
            end
         end
         StSetup: begin
            cnt_d   = '0;
            state_d = StAccess;
         end
         StAccess: begin
            // pready wins over a timeout firing in the same cycle
            if (pready) begin
               rdata_d = we_q ? '0 : prdata;
               err_d   = pslverr;
               state_d = StResp;
            end else if (TIMEOUT != 0) begin
               if (cnt_q == CntMax) begin
                  err_d   = 1'b1;
                  rdata_d = '0;
                  state_d = StResp;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StResp: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   // Bus strobes decode straight from state so reset drops them asynchronously
   assign gnt_o    = (state_q == StIdle) && req_i;
   assign psel     = (state_q == StSetup) || (state_q == StAccess);
   assign penable  = (state_q == StAccess);
   assign rvalid_o = (state_q == StResp);
   assign rdata_o  = rvalid_o ? rdata_q : '0;
   assign err_o    = rvalid_o & err_q;
   assign paddr    = addr_q;
   assign pwdata   = wdata_q;
   assign pwrite   = we_q;

endmodule
